// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding, op codes and iteration constants for muldiv_unit
package muldiv_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV = 1'b1;
    localparam int ITER = 32;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);
endpackage

// File: rtl/abs_neg32.sv
// abs_neg32: conditional two's-complement negation (in_i: value, neg_i: negate, out_o: result)
module abs_neg32 (
    input  logic [31:0] in_i,
    input  logic        neg_i,
    output logic [31:0] out_o
);
    assign out_o = neg_i ? (~in_i + 32'd1) : in_i;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential signed 32x32 multiply / 32/32 divide, one bit per cycle
// Ports: clk, reset (async, active-high); start/op/a/b request inputs;
//        hi/lo result, done pulse, busy while not idle, div_zero flag.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done,
    output logic        busy,
    output logic        div_zero
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
    logic [31:0]      mag_q, mag_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
    logic [63:0]      acc_q, acc_d, step_acc;
    logic [31:0]      abs_a, abs_b, fix_lo, fix_hi, sub, step_rem;
    logic [32:0]      msum, shifted;
    logic             ge, is_dz;
    // MULT: acc = {partial hi, multiplier}; add magnitude on LSB, shift right with carry.
    assign msum = {1'b0, acc_q[63:32]} + {1'b0, acc_q[0] ? mag_q : 32'd0};
    // DIV: acc[31:0] shifts dividend out and quotient in; remainder < |b| <= 2^31,
    // so a 32-bit difference is exact whenever the trial subtraction succeeds.
    assign shifted = {rem_q, acc_q[31]};
    assign ge = shifted[32] | (shifted[31:0] >= mag_q);
    assign sub = shifted[31:0] - mag_q;
    assign step_rem = ge ? sub : shifted[31:0];
    assign step_acc = (op_q == OP_DIV) ? {acc_q[63:32], acc_q[30:0], ge} : {msum, acc_q[31:1]};
    assign is_dz = (op == OP_DIV) && (b == '0);
    abs_neg32 u_abs_a (.in_i(a), .neg_i(a[31]), .out_o(abs_a));
    abs_neg32 u_abs_b (.in_i(b), .neg_i(b[31]), .out_o(abs_b));
    abs_neg32 u_fix_lo (.in_i(step_acc[31:0]), .neg_i(neg_res_q), .out_o(fix_lo));
    abs_neg32 u_fix_hi (
        .in_i (op_q == OP_DIV ? step_rem : step_acc[63:32]),
        .neg_i(op_q == OP_DIV ? neg_rem_q : neg_res_q),
        .out_o(fix_hi)
    );
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        mag_d     = mag_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: if (start) begin
                op_d      = op;
                neg_res_d = a[31] ^ b[31];
                neg_rem_d = a[31];
                mag_d     = (op == OP_DIV) ? abs_b : abs_a;
                acc_d     = {32'd0, (op == OP_DIV) ? abs_a : abs_b};
                rem_d     = '0;
                cnt_d     = CNT_LOAD;
                dz_d      = is_dz;
                state_d   = is_dz ? S_DONE : S_RUN;
            end
            S_RUN: begin
                acc_d = step_acc;
                rem_d = step_rem;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    lo_d    = fix_lo;
                    // 64-bit negate: upper word borrows unless the low word is zero
                    hi_d    = fix_hi - {31'd0, (op_q == OP_MULT) && neg_res_q && (step_acc[31:0] != '0)};
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            mag_q     <= '0;
            rem_q     <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            mag_q     <= mag_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE);
    assign div_zero = dz_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Sequential signed multiply/divide responder for the multicycle datapath. The control unit acts as initiator: it pulses `start` with an operation select and the A/B register contents, then waits for `done`. The block returns a 64-bit product or a quotient/remainder pair on `hi`/`lo`, which feed the Hi/Lo registers. Division by zero is flagged on `div_zero`.

## Interface
- Parameters: none. Datapath width is fixed at 32. The iteration count `ITER` = 32 comes from the shared package.
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  request; sampled only in IDLE
- `op`  in  1  0 = MULT (signed), 1 = DIV (signed); sampled with `start`
- `a`  in  32  multiplicand or dividend; sampled with `start`
- `b`  in  32  multiplier or divisor; sampled with `start`
- `hi`  out  32  MULT: product[63:32]; DIV: remainder; reset 0
- `lo`  out  32  MULT: product[31:0]; DIV: quotient; reset 0
- `done`  out  1  one-cycle pulse; `hi`/`lo`/`div_zero` are valid in that cycle; reset 0
- `busy`  out  1  high whenever state ≠ IDLE; reset 0
- `div_zero`  out  1  set on an accepted DIV with `b` == 0; reset 0

## Operation
- States:
  - IDLE → RUN on `start`, for MULT, or for DIV with `b` ≠ 0.
  - IDLE → DONE on `start` for DIV with `b` == 0.
  - RUN → DONE when the iteration counter reaches 0.
  - DONE → IDLE unconditionally.
- Accept: in IDLE with `start` = 1, latch `op`, the sign of each operand, the magnitudes `|a|` and `|b|`, and the result sign. Load counter = 31.
- `div_zero` is updated on every accepted start: 1 if DIV with `b` == 0, else 0. It holds until the next accept.
- MULT: unsigned shift-add of the magnitudes into a 64-bit accumulator, one multiplier bit per RUN cycle. Result sign = `a[31]` XOR `b[31]`.
- DIV: restoring division of the magnitudes, one quotient bit per RUN cycle, with a 33-bit partial remainder.
  - Quotient sign = `a[31]` XOR `b[31]`; rounding truncates toward zero.
  - Remainder sign follows the dividend.
  - Nonzero remainder always satisfies |rem| < |b|.
- Negation is two's complement mod 2^32 (mod 2^64 for the product). So 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, with no flag.
- On the final RUN edge, the sign-corrected result is written to `hi`/`lo` and `done` is set.
- Divide-by-zero: `hi`/`lo` keep their previous values; `done` pulses with `div_zero` = 1.
- `hi`/`lo` change only on a completing edge or on reset; they hold between operations.
- `start` outside IDLE, including the DONE cycle, is ignored with no side effect. `a`/`b`/`op` changes after accept have no effect.

## Timing
- Accept edge E0. RUN occupies the cycles between E0 and E32, which is 32 edges, E1..E32.
- E32 writes `hi`/`lo`; `done` = 1 between E32 and E33; E33 returns to IDLE.
- The earliest next accept is E34, because `start` must be high in the IDLE cycle following E33.
- Div-by-zero: `done` = 1 between E0 and E1; IDLE at E1.
- `busy` = 1 from after E0 through the DONE cycle inclusive.
- Latency is fixed and data-independent: zero operands still take 32 RUN cycles.
- Reset asserted mid-operation: all outputs go to 0 immediately and state → IDLE. No `done` is produced for the aborted op. The first `start` after deassertion is accepted normally.

## Structure
- Package `muldiv_pkg`:
  - state encoding: IDLE, RUN, DONE
  - `OP_MULT` = 1'b0, `OP_DIV` = 1'b1
  - `ITER` = 32
  - counter width 5
- One sub-module: `abs_neg32`, a combinational helper with 32-bit in, a `neg` control, and 32-bit out. It is reused for operand magnitude and for result sign correction. All sequential logic stays in `muldiv_unit`.

## Test plan
- MULT a = 7, b = 0xFFFFFFFD (−3) → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB; `done` exactly 32 edges after accept; `div_zero` = 0.
- MULT a = b = 0x7FFFFFFF → `hi` = 0x3FFFFFFF, `lo` = 0x00000001. Then MULT 0x80000000 × 0x80000000 → `hi` = 0x40000000, `lo` = 0.
- DIV a = 0xFFFFFFF9 (−7), b = 2 → `lo` = 0xFFFFFFFD (−3), `hi` = 0xFFFFFFFF (−1). DIV 7 / −2 → `lo` = 0xFFFFFFFD, `hi` = 1.
- DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0, `div_zero` = 0.
- Divide-by-zero sequence:
  - Stimulus: DIV 100 / 7 (`hi` = 2, `lo` = 14), then DIV 5 / 0.
  - Response: `done` one cycle after accept, `div_zero` = 1, `hi`/`lo` still 2/14, `busy` low at E1.
  - A following MULT clears `div_zero`.
- Abort and busy handling:
  - Stimulus: assert `reset` 10 cycles into a MULT; on release, pulse `start` with MULT 3 × 4.
  - Response: outputs go to 0 with no `done`; the new op yields `lo` = 12.
  - Also: `start` pulsed during RUN and during DONE is ignored, verified by unchanged result and timing.
